ft_cmd_decoder: RTL and testbench

FT_CMD_DECODER -- requirements
Module: ft_cmd_decoder

---
 rtl/ft_cmd_decoder_pkg.sv | 41 ++++
 rtl/ft245_rx_if.sv | 92 +++++++++
 rtl/ft_cmd_decoder.sv | 128 ++++++++++++
 tb/tb_ft_cmd_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_cmd_decoder_pkg.sv
// Shared opcodes, FSM state types and pulse bundle for the FT232H command decoder.
package ft_cmd_decoder_pkg;

  localparam logic [7:0] OP_SET_REGISTER   = 8'h01;
  localparam logic [7:0] OP_RW_ADCONF      = 8'h02;
  localparam logic [7:0] OP_OPEN_SHUTTER   = 8'h03;
  localparam logic [7:0] OP_CLOSE_SHUTTER  = 8'h04;
  localparam logic [7:0] OP_TOGGLE_READ    = 8'h05;
  localparam logic [7:0] OP_TOGGLE_MCP     = 8'h06;

  localparam int TO_CNT_W = 17;

  typedef enum logic [2:0] {
    R_IDLE,
    R_OE,
    R_RD,
    R_REL,
    R_WAIT
  } rx_state_t;

  typedef enum logic [1:0] {
    P_CMD,
    P_ARG1,
    P_ARG2
  } parse_state_t;

  typedef struct packed {
    logic reg_wr;
    logic ad_cfg_wr;
    logic shutter_open;
    logic shutter_close;
    logic ccd_read_toggle;
    logic mcp_toggle;
    logic cmd_err;
  } pulse_t;

  function automatic logic is_arg_op(input logic [7:0] op);
    return (op == OP_SET_REGISTER) || (op == OP_RW_ADCONF);
  endfunction

endpackage

// File: rtl/ft245_rx_if.sv
// FT232H FT245-style read engine: one byte per handshake, byte_vld 1 cycle in R_REL.
// Waits in R_IDLE while byte_rdy is low; ft_rd_n is only ever low inside the ft_oe_n window.
module ft245_rx_if
  import ft_cmd_decoder_pkg::*;
#(
  parameter int RD_LOW_CYCLES = 3
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic [7:0] ft_bus_in,
  input  logic       ft_rxf_n,
  output logic       ft_oe_n,
  output logic       ft_rd_n,
  input  logic       byte_rdy,
  output logic       byte_vld,
  output logic [7:0] byte_dat
);

  localparam logic [3:0] RD_LAST = 4'(RD_LOW_CYCLES - 1);

  logic      rxf_meta;
  logic      rxf_sync;
  rx_state_t state;
  logic [3:0] rd_cnt;
  logic [2:0] wait_cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rxf_meta <= 1'b1;
      rxf_sync <= 1'b1;
    end else begin
      rxf_meta <= ft_rxf_n;
      rxf_sync <= rxf_meta;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state    <= R_IDLE;
      ft_oe_n  <= 1'b1;
      ft_rd_n  <= 1'b1;
      byte_vld <= 1'b0;
      byte_dat <= 8'h00;
      rd_cnt   <= 4'd0;
      wait_cnt <= 3'd0;
    end else begin
      byte_vld <= 1'b0;
      case (state)
        R_IDLE: begin
          if (!rxf_sync && byte_rdy) begin
            ft_oe_n <= 1'b0;
            state   <= R_OE;
          end
        end
        R_OE: begin
          ft_rd_n <= 1'b0;
          rd_cnt  <= 4'd0;
          state   <= R_RD;
        end
        R_RD: begin
          if (rd_cnt == RD_LAST) begin
            byte_dat <= ft_bus_in;
            byte_vld <= 1'b1;
            ft_rd_n  <= 1'b1;
            ft_oe_n  <= 1'b1;
            state    <= R_REL;
          end else begin
            rd_cnt <= rd_cnt + 4'd1;
          end
        end
        R_REL: begin
          wait_cnt <= 3'd0;
          state    <= R_WAIT;
        end
        R_WAIT: begin
          // rxf_n lags the read by the synchronizer; the cap stops a stuck-low flag from hanging us.
          if (rxf_sync || (wait_cnt == 3'd7)) begin
            state <= R_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        default: begin
          state   <= R_IDLE;
          ft_oe_n <= 1'b1;
          ft_rd_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/ft_cmd_decoder.sv
// Host command parser over the FT245 read engine; pulses appear 1 cycle after the final byte_vld.
// Multi-byte commands abort with cmd_err if the next byte does not arrive within ARG_TIMEOUT cycles.
module ft_cmd_decoder
  import ft_cmd_decoder_pkg::*;
#(
  parameter int RD_LOW_CYCLES = 3,
  parameter int ARG_TIMEOUT   = 100000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [7:0]  ft_bus_in,
  input  logic        ft_rxf_n,
  output logic        ft_oe_n,
  output logic        ft_rd_n,
  output logic        reg_wr,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_data,
  output logic        ad_cfg_wr,
  output logic [15:0] ad_cfg_word,
  output logic        shutter_open,
  output logic        shutter_close,
  output logic        ccd_read_toggle,
  output logic        mcp_toggle,
  output logic        cmd_err
);

  localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(ARG_TIMEOUT - 1);

  logic                byte_vld;
  logic [7:0]          byte_dat;
  logic                byte_rdy;
  parse_state_t        pstate;
  logic [7:0]          op_q;
  logic [7:0]          addr_q;
  logic [TO_CNT_W-1:0] to_cnt;
  pulse_t              pulse_q;

  // The parser consumes any byte in the cycle it arrives, so it never stalls the reader.
  assign byte_rdy = 1'b1;

  ft245_rx_if #(
    .RD_LOW_CYCLES(RD_LOW_CYCLES)
  ) u_rx (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .ft_bus_in(ft_bus_in),
    .ft_rxf_n (ft_rxf_n),
    .ft_oe_n  (ft_oe_n),
    .ft_rd_n  (ft_rd_n),
    .byte_rdy (byte_rdy),
    .byte_vld (byte_vld),
    .byte_dat (byte_dat)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pstate      <= P_CMD;
      op_q        <= 8'h00;
      addr_q      <= 8'h00;
      to_cnt      <= '0;
      pulse_q     <= '0;
      reg_addr    <= 8'h00;
      reg_data    <= 8'h00;
      ad_cfg_word <= 16'h0000;
    end else begin
      pulse_q <= '0;
      case (pstate)
        P_CMD: begin
          if (byte_vld) begin
            to_cnt <= '0;
            if (is_arg_op(byte_dat)) begin
              op_q   <= byte_dat;
              pstate <= P_ARG1;
            end else begin
              case (byte_dat)
                OP_OPEN_SHUTTER:  pulse_q.shutter_open    <= 1'b1;
                OP_CLOSE_SHUTTER: pulse_q.shutter_close   <= 1'b1;
                OP_TOGGLE_READ:   pulse_q.ccd_read_toggle <= 1'b1;
                OP_TOGGLE_MCP:    pulse_q.mcp_toggle      <= 1'b1;
                default:          pulse_q.cmd_err         <= 1'b1;
              endcase
            end
          end
        end
        P_ARG1, P_ARG2: begin
          // A byte landing on the expiry cycle still counts as on time.
          if (byte_vld) begin
            to_cnt <= '0;
            if (pstate == P_ARG1) begin
              addr_q <= byte_dat;
              pstate <= P_ARG2;
            end else begin
              if (op_q == OP_SET_REGISTER) begin
                pulse_q.reg_wr <= 1'b1;
                reg_addr       <= addr_q;
                reg_data       <= byte_dat;
              end else begin
                pulse_q.ad_cfg_wr <= 1'b1;
                ad_cfg_word       <= {addr_q, byte_dat};
              end
              op_q   <= 8'h00;
              addr_q <= 8'h00;
              pstate <= P_CMD;
            end
          end else if (to_cnt == TO_LAST) begin
            pulse_q.cmd_err <= 1'b1;
            op_q            <= 8'h00;
            addr_q          <= 8'h00;
            to_cnt          <= '0;
            pstate          <= P_CMD;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: pstate <= P_CMD;
      endcase
    end
  end

  assign reg_wr          = pulse_q.reg_wr;
  assign ad_cfg_wr       = pulse_q.ad_cfg_wr;
  assign shutter_open    = pulse_q.shutter_open;
  assign shutter_close   = pulse_q.shutter_close;
  assign ccd_read_toggle = pulse_q.ccd_read_toggle;
  assign mcp_toggle      = pulse_q.mcp_toggle;
  assign cmd_err         = pulse_q.cmd_err;

endmodule

// File: tb/tb_ft_cmd_decoder.sv
// Bench for ft_cmd_decoder: FT232H host model feeding table vectors plus timeout and reset sequences.
module tb_ft_cmd_decoder;

  localparam int RD_LOW = 3;
  localparam int TO     = 400;

  logic        clk_in    = 1'b0;
  logic        rst_n     = 1'b1;
  logic [7:0]  ft_bus_in = 8'hEE;
  logic        ft_rxf_n  = 1'b1;
  logic        ft_oe_n, ft_rd_n;
  logic        reg_wr, ad_cfg_wr, shutter_open, shutter_close;
  logic        ccd_read_toggle, mcp_toggle, cmd_err;
  logic [7:0]  reg_addr, reg_data;
  logic [15:0] ad_cfg_word;

  always #5 clk_in = ~clk_in;

  ft_cmd_decoder #(.RD_LOW_CYCLES(RD_LOW), .ARG_TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .ft_bus_in(ft_bus_in), .ft_rxf_n(ft_rxf_n),
    .ft_oe_n(ft_oe_n), .ft_rd_n(ft_rd_n), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_data(reg_data), .ad_cfg_wr(ad_cfg_wr), .ad_cfg_word(ad_cfg_word),
    .shutter_open(shutter_open), .shutter_close(shutter_close),
    .ccd_read_toggle(ccd_read_toggle), .mcp_toggle(mcp_toggle), .cmd_err(cmd_err)
  );

  // Host FIFO model: data valid only while ft_rd_n is low, rxf_n high for a few cycles after each read.
  logic [7:0] tx_buf [0:63];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   gap    = 0;
  logic rd_prev = 1'b1;

  always @(negedge clk_in) begin
    if (gap > 0) gap--;
    if (!rd_prev && ft_rd_n && (rd_ptr != wr_ptr)) begin
      rd_ptr++;
      gap = 4;
    end
    rd_prev   = ft_rd_n;
    ft_rxf_n  = !((rd_ptr != wr_ptr) && (gap == 0));
    ft_bus_in = (!ft_rd_n && (rd_ptr != wr_ptr)) ? tx_buf[rd_ptr % 64] : 8'hEE;
  end

  // Output monitor
  int n_reg = 0, n_ad = 0, n_open = 0, n_close = 0, n_ccd = 0, n_mcp = 0, n_err = 0;
  int n_onehot = 0, n_proto = 0, np = 0;
  int rd_run = 0, oe_run = 0, last_rd_low = 0, last_oe_lead = 0;

  always @(negedge clk_in) begin
    if (rst_n) begin
      np = int'(reg_wr) + int'(ad_cfg_wr) + int'(shutter_open) + int'(shutter_close) +
           int'(ccd_read_toggle) + int'(mcp_toggle) + int'(cmd_err);
      if (np > 1) n_onehot++;
      if (!ft_rd_n && ft_oe_n) n_proto++;
      n_reg   += int'(reg_wr);
      n_ad    += int'(ad_cfg_wr);
      n_open  += int'(shutter_open);
      n_close += int'(shutter_close);
      n_ccd   += int'(ccd_read_toggle);
      n_mcp   += int'(mcp_toggle);
      n_err   += int'(cmd_err);
      if (!ft_rd_n) begin
        if (rd_run == 0) last_oe_lead = oe_run;
        rd_run++;
      end else begin
        if (rd_run > 0) last_rd_low = rd_run;
        rd_run = 0;
        if (!ft_oe_n) oe_run++;
        else oe_run = 0;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  int b_reg, b_ad, b_open, b_close, b_ccd, b_mcp, b_err;

  task automatic snap();
    b_reg = n_reg; b_ad = n_ad; b_open = n_open; b_close = n_close;
    b_ccd = n_ccd; b_mcp = n_mcp; b_err = n_err;
  endtask

  task automatic check_counts(input string tag, input int er, input int ea, input int eo,
                              input int ec, input int ecc, input int em, input int ee);
    check({tag, "_reg_wr"},    n_reg - b_reg, er);
    check({tag, "_ad_cfg_wr"}, n_ad - b_ad, ea);
    check({tag, "_open"},      n_open - b_open, eo);
    check({tag, "_close"},     n_close - b_close, ec);
    check({tag, "_ccd"},       n_ccd - b_ccd, ecc);
    check({tag, "_mcp"},       n_mcp - b_mcp, em);
    check({tag, "_cmd_err"},   n_err - b_err, ee);
  endtask

  task automatic push(input logic [7:0] b);
    tx_buf[wr_ptr % 64] = b;
    wr_ptr++;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rd_ptr != wr_ptr) && (n < 3000)) begin
      @(negedge clk_in);
      n++;
    end
    check("host_drain", (rd_ptr == wr_ptr) ? 1 : 0, 1);
    repeat (40) @(negedge clk_in);
  endtask

  typedef struct {
    int          nb;
    logic [7:0]  b0, b1, b2;
    int          e_reg, e_ad, e_open, e_close, e_ccd, e_mcp, e_err;
    logic [7:0]  e_addr, e_data;
    logic [15:0] e_word;
  } vec_t;

  vec_t vecs [0:9];

  initial begin
    int n;
    vecs[0] = '{3, 8'h01, 8'h02, 8'h02, 1, 0, 0, 0, 0, 0, 0, 8'h02, 8'h02, 16'h0000};
    vecs[1] = '{1, 8'h05, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 16'h0000};
    vecs[2] = '{3, 8'h02, 8'h40, 8'h03, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h4003};
    vecs[3] = '{2, 8'hFF, 8'h03, 8'h00, 0, 0, 1, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0000};
    vecs[4] = '{1, 8'h03, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 8'h00, 8'h00, 16'h0000};
    vecs[5] = '{1, 8'h04, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 0, 8'h00, 8'h00, 16'h0000};
    vecs[6] = '{1, 8'h06, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00, 16'h0000};
    vecs[7] = '{3, 8'h01, 8'hAB, 8'hCD, 1, 0, 0, 0, 0, 0, 0, 8'hAB, 8'hCD, 16'h0000};
    vecs[8] = '{1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 8'h00, 8'h00, 16'h0000};
    vecs[9] = '{3, 8'h02, 8'h00, 8'hFF, 0, 1, 0, 0, 0, 0, 0, 8'h00, 8'h00, 16'h00FF};

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk_in);
    check("rst_oe_n", int'(ft_oe_n), 1);
    check("rst_rd_n", int'(ft_rd_n), 1);
    check("rst_pulses", int'({reg_wr, ad_cfg_wr, shutter_open, shutter_close,
                              ccd_read_toggle, mcp_toggle, cmd_err}), 0);
    check("rst_reg_addr", int'(reg_addr), 0);
    check("rst_reg_data", int'(reg_data), 0);
    check("rst_ad_word", int'(ad_cfg_word), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in);

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      snap();
      push(vecs[i].b0);
      if (vecs[i].nb > 1) push(vecs[i].b1);
      if (vecs[i].nb > 2) push(vecs[i].b2);
      wait_idle();
      check_counts($sformatf("vec%0d", i), vecs[i].e_reg, vecs[i].e_ad, vecs[i].e_open,
                   vecs[i].e_close, vecs[i].e_ccd, vecs[i].e_mcp, vecs[i].e_err);
      if (vecs[i].e_reg > 0) begin
        check($sformatf("vec%0d_reg_addr", i), int'(reg_addr), int'(vecs[i].e_addr));
        check($sformatf("vec%0d_reg_data", i), int'(reg_data), int'(vecs[i].e_data));
      end
      if (vecs[i].e_ad > 0)
        check($sformatf("vec%0d_ad_word", i), int'(ad_cfg_word), int'(vecs[i].e_word));
    end

    // Read strobe timing on a single-byte command
    snap();
    push(8'h05);
    wait_idle();
    check("rd_low_cycles", last_rd_low, RD_LOW);
    check("oe_lead_cycles", last_oe_lead, 1);
    check_counts("timing", 0, 0, 0, 0, 1, 0, 0);

    // Slow but in-time argument bytes
    snap();
    push(8'h01);
    wait_idle();
    repeat (250) @(negedge clk_in);
    push(8'h10);
    wait_idle();
    repeat (250) @(negedge clk_in);
    push(8'h20);
    wait_idle();
    check_counts("slow", 1, 0, 0, 0, 0, 0, 0);
    check("slow_reg_addr", int'(reg_addr), 8'h10);
    check("slow_reg_data", int'(reg_data), 8'h20);

    // Timeout waiting for the data byte
    snap();
    push(8'h01);
    push(8'h00);
    wait_idle();
    check("to_early_err", n_err - b_err, 0);
    repeat (TO) @(negedge clk_in);
    check_counts("to_arg2", 0, 0, 0, 0, 0, 0, 1);
    push(8'h04);
    wait_idle();
    check_counts("to_arg2_next", 0, 0, 0, 1, 0, 0, 1);

    // Timeout waiting for the address byte
    snap();
    push(8'h02);
    wait_idle();
    repeat (TO) @(negedge clk_in);
    push(8'h06);
    wait_idle();
    check_counts("to_arg1", 0, 0, 0, 0, 0, 1, 1);

    // Reset asserted mid-read
    snap();
    push(8'h03);
    n = 0;
    while (ft_rd_n && (n < 500)) begin
      @(negedge clk_in);
      n++;
    end
    check("mid_rd_seen_low", int'(ft_rd_n), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_n", int'(ft_rd_n), 1);
    check("mid_rst_oe_n", int'(ft_oe_n), 1);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_in);
    push(8'h05);
    wait_idle();
    check_counts("after_rst", 0, 0, 0, 0, 1, 0, 0);

    check("onehot_violations", n_onehot, 0);
    check("rd_without_oe", n_proto, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
